// File: rtl/seg7_pkg.sv
// Shared constants, display codes and FSM state type for the scrolling 7-segment controller.
package seg7_pkg;

   localparam int NUM_DIGITS = 5;
   localparam int BIN_W      = 16;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   localparam logic [3:0] SIGN_CODE  = 4'hB;
   localparam logic [3:0] BLANK_CODE = 4'hF;

   localparam logic [3:0] AN_SLOT0 = 4'b0111;
   localparam logic [3:0] AN_SLOT1 = 4'b1011;
   localparam logic [3:0] AN_SLOT2 = 4'b1101;
   localparam logic [3:0] AN_SLOT3 = 4'b1110;
   localparam logic [3:0] AN_OFF   = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      READY
   } state_e;

   // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
   function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      r = s;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_scroll_ctrl_bin2bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter, one double-dabble step per cycle.
module bin2bcd_seq
   import seg7_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd_out
);

   logic [BIN_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [BCD_W-1:0] bcd_step;

   always_comb begin
      bcd_step = add3_adjust(bcd_q);
      bcd_step = {bcd_step[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (busy_q) begin
         bin_d = {bin_q[BIN_W-2:0], 1'b0};
         bcd_d = bcd_step;
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == 4'd15) busy_d = 1'b0;
      end else if (start) begin
         bin_d  = bin_in;
         bcd_d  = '0;
         cnt_d  = 4'd0;
         busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= 4'd0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   // The final step's result is handed out combinationally so the caller can load it on this edge.
   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == 4'd15);
   assign bcd_out = bcd_step;

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Scrolling 5-digit 7-segment controller: button sync, BCD conversion, rotation and anode scan.
// Build option: define LEADING_ZERO_BLANK_EN to store leading zeros of d0..d3 as blanks.
module seg7_scroll_ctrl
   import seg7_pkg::*;
#(
   parameter int SCAN_W      = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sl,
   input  logic             sr,
   input  logic [BIN_W-1:0] sw,
   output logic [3:0]       an,
   output logic [3:0]       digit,
   output logic             busy,
   output logic             valid
);

   logic [2:0]        sync_q [SYNC_STAGES];
   logic [2:0]        sync_d [SYNC_STAGES];
   logic [2:0]        edge_q, edge_d, rise;
   state_e            state_q, state_d;
   logic [3:0]        d_q [NUM_DIGITS];
   logic [3:0]        d_d [NUM_DIGITS];
   logic [SCAN_W-1:0] cnt_q, cnt_d;
   logic [3:0]        an_q, an_d, digit_q, digit_d;
   logic              conv_start, conv_busy, conv_done;
   logic [BCD_W-1:0]  conv_bcd;
   logic              lead;

   always_comb begin
      sync_d[0] = {start, sl, sr};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      edge_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~edge_q;
   end

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .start   (conv_start),
      .bin_in  (sw),
      .busy    (conv_busy),
      .done    (conv_done),
      .bcd_out (conv_bcd)
   );

   // rise = {start, sl, sr}; start outranks rotation, opposing rotations cancel.
   always_comb begin
      state_d    = state_q;
      conv_start = 1'b0;
      lead       = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) d_d[i] = d_q[i];
      case (state_q)
         IDLE: begin
            if (rise[2]) begin
               conv_start = 1'b1;
               state_d    = CONVERT;
            end
         end
         CONVERT: begin
            if (conv_done) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  d_d[i] = conv_bcd[4*(NUM_DIGITS-1-i) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                  if (i < NUM_DIGITS - 1 && lead && d_d[i] == 4'd0) d_d[i] = BLANK_CODE;
                  else lead = 1'b0;
`endif
               end
               state_d = READY;
            end
         end
         READY: begin
            if (rise[2]) begin
               conv_start = 1'b1;
               state_d    = CONVERT;
            end else if (rise[1] && !rise[0]) begin
               for (int i = 0; i < NUM_DIGITS; i++) d_d[i] = d_q[(i + 1) % NUM_DIGITS];
            end else if (rise[0] && !rise[1]) begin
               for (int i = 0; i < NUM_DIGITS; i++) d_d[i] = d_q[(i + NUM_DIGITS - 1) % NUM_DIGITS];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q + {{(SCAN_W-1){1'b0}}, 1'b1};
      case (cnt_q[SCAN_W-1 -: 2])
         2'd0:    begin an_d = AN_SLOT0; digit_d = SIGN_CODE; end
         2'd1:    begin an_d = AN_SLOT1; digit_d = (state_q == READY) ? d_q[0] : BLANK_CODE; end
         2'd2:    begin an_d = AN_SLOT2; digit_d = (state_q == READY) ? d_q[1] : BLANK_CODE; end
         default: begin an_d = AN_SLOT3; digit_d = (state_q == READY) ? d_q[2] : BLANK_CODE; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
         edge_q  <= 3'b000;
         state_q <= IDLE;
         for (int i = 0; i < NUM_DIGITS; i++) d_q[i] <= 4'd0;
         cnt_q   <= '0;
         an_q    <= AN_OFF;
         digit_q <= BLANK_CODE;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
         edge_q  <= edge_d;
         state_q <= state_d;
         for (int i = 0; i < NUM_DIGITS; i++) d_q[i] <= d_d[i];
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         digit_q <= digit_d;
      end
   end

   assign an    = an_q;
   assign digit = digit_q;
   assign busy  = conv_busy;
   assign valid = (state_q == READY);

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Randomized scoreboard bench for seg7_scroll_ctrl; the model derives digits by decimal arithmetic.
module tb_seg7_scroll_ctrl;
   import seg7_pkg::*;

   localparam int SCAN_W = 4;

   logic        clk = 1'b0;
   logic        rst, start, sl, sr;
   logic [15:0] sw;
   logic [3:0]  an, digit;
   logic        busy, valid;

   seg7_scroll_ctrl #(.SCAN_W(SCAN_W), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .sl(sl), .sr(sr), .sw(sw),
      .an(an), .digit(digit), .busy(busy), .valid(valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] win;
      int          tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   exp_d[5];
   bit   model_valid = 1'b0;
   int   tag_n = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   // Reference: decimal digits by division; blanking of leading zeros when built with the option.
   task automatic model_convert(input int v);
      int p10[5];
      bit lead;
      p10 = '{10000, 1000, 100, 10, 1};
      lead = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_d[k] = (v / p10[k]) % 10;
`ifdef LEADING_ZERO_BLANK_EN
         if (k < 4 && lead && exp_d[k] == 0) exp_d[k] = 15;
         else lead = 1'b0;
`endif
      end
      model_valid = 1'b1;
   endtask

   task automatic model_rotate(input logic [2:0] m);
      int t;
      if (m == 3'b010) begin
         t = exp_d[0];
         for (int k = 0; k < 4; k++) exp_d[k] = exp_d[k+1];
         exp_d[4] = t;
      end else if (m == 3'b001) begin
         t = exp_d[4];
         for (int k = 4; k > 0; k--) exp_d[k] = exp_d[k-1];
         exp_d[0] = t;
      end
   endtask

   task automatic expect_window();
      exp_t e;
      if (model_valid) e.win = {4'hB, exp_d[0][3:0], exp_d[1][3:0], exp_d[2][3:0]};
      else             e.win = 16'hBFFF;
      e.tag = tag_n++;
      exp_q.push_back(e);
      for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL scan_timeout: tag %0d still pending, required drained queue", e.tag);
         exp_q.delete();
      end
   endtask

   // Monitor: on each entry into slot 0, captures one full 16-cycle counter period and scores it.
   initial begin
      logic [3:0] prev_an, req_an, req_dig;
      logic [15:0] got_an, got_dig;
      logic [3:0]  slot_an[4];
      bit ok;
      slot_an = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      prev_an = 4'b1111;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0 && !rst && an == 4'b0111 && prev_an != 4'b0111) begin
            ok = 1'b1;
            got_an = 16'h0; got_dig = 16'h0;
            for (int n = 0; n < 16; n++) begin
               if (n > 0) @(negedge clk);
               req_an  = slot_an[n/4];
               req_dig = exp_q[0].win[15 - 4*(n/4) -: 4];
               if (n % 4 == 0) begin
                  got_an[15 - 4*(n/4) -: 4]  = an;
                  got_dig[15 - 4*(n/4) -: 4] = digit;
               end
               if (an !== req_an || digit !== req_dig) ok = 1'b0;
            end
            checks++;
            if (ok) passed++;
            else $display("FAIL scan_tag%0d: an %h digit %h, required an 7BDE digit %h",
                          exp_q[0].tag, got_an, got_dig, exp_q[0].win);
            $display("scan tag %0d window %h", exp_q[0].tag, exp_q[0].win);
            void'(exp_q.pop_front());
            prev_an = an;
         end else begin
            prev_an = an;
         end
      end
   end

   task automatic press(input logic [2:0] m);
      @(negedge clk);
      {start, sl, sr} = m;
      repeat (3) @(negedge clk);
      {start, sl, sr} = 3'b000;
      repeat (4) @(negedge clk);
   endtask

   task automatic rotate(input logic [2:0] m);
      press(m);
      model_rotate(m);
      $display("rotate %b", m);
      expect_window();
   endtask

   task automatic convert(input int v, input bit sl_during);
      int n, bcnt;
      @(negedge clk);
      sw = v[15:0];
      start = 1'b1;
      for (n = 0; n < 20 && !busy; n++) @(negedge clk);
      chk("busy_rise", {15'd0, busy}, 16'd1);
      bcnt = 0;
      while (busy && bcnt < 40) begin
         if (sl_during && bcnt == 2) sl = 1'b1;
         if (sl_during && bcnt == 6) sl = 1'b0;
         bcnt++;
         @(negedge clk);
      end
      chk("busy_cycles", bcnt[15:0], 16'd16);
      chk("valid_at_T17", {15'd0, valid}, 16'd1);
      start = 1'b0;
      sl = 1'b0;
      model_convert(v);
      $display("convert sw=%0d", v);
      expect_window();
   endtask

   initial begin
      int v;
      logic [2:0] m;
      logic [2:0] mtab[3];
      mtab = '{3'b010, 3'b001, 3'b011};
      rst = 1'b1; start = 1'b0; sl = 1'b0; sr = 1'b0; sw = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_an", {12'h0, an}, 16'h000F);
      chk("rst_digit", {12'h0, digit}, 16'h000F);
      chk("rst_busy_valid", {14'h0, busy, valid}, 16'h0);
      rst = 1'b0;
      expect_window();

      convert(12345, 1'b0);
      rotate(3'b010);
      rotate(3'b001);
      rotate(3'b001);
      rotate(3'b010);
      rotate(3'b010);
      convert(65535, 1'b0);
      convert(7, 1'b0);
      rotate(3'b011);
      convert(40960, 1'b1);

      // Reset five cycles into a conversion.
      @(negedge clk);
      sw = 16'd54321;
      start = 1'b1;
      for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy_valid", {14'h0, busy, valid}, 16'h0);
      chk("midrst_an", {12'h0, an}, 16'h000F);
      chk("midrst_digit", {12'h0, digit}, 16'h000F);
      rst = 1'b0;
      start = 1'b0;
      model_valid = 1'b0;
      $display("reset during convert");
      expect_window();
      convert(54321, 1'b0);

      for (int t = 0; t < 6; t++) begin
         v = int'($urandom_range(0, 65535));
         convert(v, 1'b0);
         for (int r = 0; r < 3; r++) begin
            m = mtab[$urandom_range(0, 2)];
            rotate(m);
         end
      end
      convert(0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seg7_scroll_ctrl.md
Name: seg7_scroll_ctrl

Overview:
Sequencing controller for the 5-digit scrolling 7-segment display datapath. It captures the 16-bit switch value on a start request and converts it to five BCD digits with a multi-cycle double-dabble engine. It rotates the digit window on shift-left/right requests and time-multiplexes sign + 3 window digits onto the 4-anode display. Its digit code output drives the existing 7-segment decoder.

Parameters:
SCAN_W, 20, refresh counter width; anode slot = cnt[SCAN_W-1:SCAN_W-2]
SYNC_STAGES, 2, synchroniser flops per button input (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  raw button: capture sw and convert
sl  in  1  raw button: rotate window left
sr  in  1  raw button: rotate window right
sw  in  16  unsigned binary value, 0..65535
an  out  4  anode enables, active-low, registered
digit  out  4  BCD/code to decoder, registered; 4'hB = sign, 4'hF = blank
busy  out  1  high while converting
valid  out  1  digits d0..d4 hold a converted value

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE; d0..d4=0; busy=0; valid=0; refresh counter=0; synchronisers/edge regs=0; an=4'b1111; digit=4'hF.
- Inputs pass through SYNC_STAGES flops, then a 1-cycle edge register; *_rise = single-cycle pulse per press.
- FSM:
  - IDLE: start_rise -> latch sw into shift reg, bcd scratch=0, bitcnt=0, CONVERT.
  - CONVERT: busy=1; one shift-add-3 step/cycle, 16 cycles; on 16th step load d0(ten-thousands)..d4(units), go READY. start/sl/sr rises ignored.
  - READY: valid=1; start_rise -> reconvert (valid drops next cycle, busy rises); sl_rise -> (d0..d4) <= (d1,d2,d3,d4,d0); sr_rise -> (d0..d4) <= (d4,d0,d1,d2,d3).
- Latency: start_rise at cycle T -> busy=1 from T+1; digits and valid=1 from T+17.
- Simultaneous: start_rise beats sl/sr; sl_rise && sr_rise same cycle -> no rotation.
- sl/sr in IDLE: ignored.
- Scan: refresh counter free-runs in all states, wraps at 2^SCAN_W. Slot 0: an=0111, digit=4'hB. Slot 1: an=1011, digit=d0. Slot 2: an=1101, digit=d1. Slot 3: an=1110, digit=d2. an/digit registered, 1 cycle after counter.
- While valid=0: slots 1-3 output digit=4'hF; sign slot still shows 4'hB.
- Arithmetic: 16-bit in, 20-bit BCD scratch; every BCD nibble <= 9 after conversion; max 65535 -> 6,5,5,3,5.
- rst mid-CONVERT: abort to IDLE, scratch discarded, valid=0.

Optional Feature:
LEADING_ZERO_BLANK_EN. Defined: on load, leading-zero digits of d0..d3 are stored as 4'hF; d4 is never blanked; blanks rotate as ordinary digits. Undefined: zeros stored as 0.

Decomposition:
- Package seg7_pkg:
  - codes SIGN_CODE=4'hB, BLANK_CODE=4'hF
  - anode patterns AN_SLOT0..3, AN_OFF=4'b1111
  - FSM state enum (IDLE, CONVERT, READY)
  - NUM_DIGITS=5, BIN_W=16
- One sub-module: bin2bcd_seq (start/busy/done, 16-cycle double-dabble).

Test Plan:
- sw=12345, start pulse -> busy 16 cycles; valid at T+17; d=1,2,3,4,5; slots 0-3 show B,1,2,3 with an 0111/1011/1101/1110.
- From 12345: sl pulse -> d=2,3,4,5,1 (display B,2,3,4). Then sr pulse twice -> d=5,1,2,3,4.
- sw=65535 -> d=6,5,5,3,5. sw=7 -> 0,0,0,0,7, or F,F,F,F,7 with LEADING_ZERO_BLANK_EN.
- sl and sr rise in same cycle in READY -> digits unchanged. sl pulse during CONVERT -> ignored.
- rst asserted 5 cycles into CONVERT -> next cycle IDLE, busy=0, valid=0, an=1111, digit=F. Subsequent start converts normally.
- Before any start: slot 0 shows B, slots 1-3 show F. Counter wrap from all-ones returns to slot 0 with no glitch slot.
